// File: rtl/o_ru_rst_sequencer.sv
// O-RU reset sequencer: staged reset release, rst pulse-width monitor
// and saturating uptime counter for the O-RU clock domain.
module o_ru_rst_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int STAGE_DELAY    = 16,
  parameter int MIN_RST_CYCLES = 5120,
  parameter int CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_err,
  output logic [NUM_STAGES-1:0] stage_rst,
  output logic                  all_ready,
  output logic [CNT_W-1:0]      rst_cycles,
  output logic                  rst_short_err,
  output logic [CNT_W-1:0]      uptime
);

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] SMAX =
    CNT_W'(NUM_STAGES * STAGE_DELAY);

  // Stages are held as "released" flags so that the all-zero
  // power-up state of every register equals the reset state.
  logic [NUM_STAGES-1:0] released;
  logic                  rst_q;
  logic [CNT_W-1:0]      rst_len;
  logic [CNT_W-1:0]      since;
  logic [CNT_W-1:0]      since_inc;
  logic                  capture;
  logic                  short_cap;

  assign stage_rst = ~released;
  assign since_inc = since + ONE;
  assign capture   = rst_q & ~rst;
  assign short_cap = capture &
    (64'(rst_len) < 64'(MIN_RST_CYCLES));

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      released  <= '0;
      all_ready <= 1'b0;
      uptime    <= '0;
      since     <= '0;
      if (!rst_q)
        rst_len <= ONE;
      else if (rst_len != CMAX)
        rst_len <= rst_len + ONE;
    end else begin
      if (since != SMAX)
        since <= since_inc;
      if (uptime != CMAX)
        uptime <= uptime + ONE;
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (64'(since_inc) == 64'((k + 1) * STAGE_DELAY))
          released[k] <= 1'b1;
      end
      if (since_inc == SMAX)
        all_ready <= 1'b1;
    end
    if (capture)
      rst_cycles <= rst_len;
    // A short capture on the same edge beats a clear request.
    if (short_cap)
      rst_short_err <= 1'b1;
    else if (clear_err)
      rst_short_err <= 1'b0;
  end

endmodule

// File: tb/tb_o_ru_rst_sequencer.sv
// Bench for o_ru_rst_sequencer: 32-bit and 8-bit counter instances in
// lockstep against a run-length reference model.
module tb_o_ru_rst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        clear_err = 1'b0;
  logic [3:0]  stage_rst, stage8;
  logic        all_ready, ready8;
  logic [31:0] rst_cycles, uptime;
  logic [7:0]  cyc8, up8;
  logic        err, err8;

  o_ru_rst_sequencer dut (
    .clk(clk), .rst(rst), .clear_err(clear_err),
    .stage_rst(stage_rst), .all_ready(all_ready),
    .rst_cycles(rst_cycles), .rst_short_err(err),
    .uptime(uptime)
  );

  o_ru_rst_sequencer #(
    .MIN_RST_CYCLES(200), .CNT_W(8)
  ) dut8 (
    .clk(clk), .rst(rst), .clear_err(clear_err),
    .stage_rst(stage8), .all_ready(ready8),
    .rst_cycles(cyc8), .rst_short_err(err8),
    .uptime(up8)
  );

  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX8  = 255;

  int tests = 0;
  int fails = 0;

  longint hi_run = 0;
  longint lo_run = 0;
  bit     prev = 1'b0;
  longint e_cyc = 0, e_cyc8 = 0;
  bit     e_err = 1'b0, e_err8 = 1'b0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      if (fails <= 30)
        $display("FAIL %s got=%0d exp=%0d t=%0t",
                 tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(longint v, longint m);
    return (v > m) ? m : v;
  endfunction

  function automatic logic [3:0] exp_stage();
    logic [3:0] s;
    for (int k = 0; k < 4; k++)
      s[k] = !(lo_run >= (k + 1) * 16);
    return s;
  endfunction

  task automatic model_step(bit r, bit c);
    bit set = 1'b0, set8 = 1'b0;
    if (r) begin
      hi_run = prev ? hi_run + 1 : 1;
      lo_run = 0;
    end else begin
      if (prev) begin
        e_cyc  = sat(hi_run, MAX32);
        e_cyc8 = sat(hi_run, MAX8);
        set    = e_cyc < 5120;
        set8   = e_cyc8 < 200;
      end
      lo_run++;
    end
    prev = r;
    e_err  = set  ? 1'b1 : (c ? 1'b0 : e_err);
    e_err8 = set8 ? 1'b1 : (c ? 1'b0 : e_err8);
  endtask

  task automatic compare_all();
    check("stage_rst", stage_rst, exp_stage());
    check("all_ready", all_ready, lo_run >= 64);
    check("uptime", uptime, sat(lo_run, MAX32));
    check("rst_cycles", rst_cycles, e_cyc);
    check("short_err", err, e_err);
    check("stage8", stage8, exp_stage());
    check("ready8", ready8, lo_run >= 64);
    check("uptime8", up8, sat(lo_run, MAX8));
    check("rst_cycles8", cyc8, e_cyc8);
    check("short_err8", err8, e_err8);
  endtask

  task automatic cycle(bit r, bit c);
    rst = r;
    clear_err = c;
    @(posedge clk);
    model_step(r, c);
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(bit r, int n);
    for (int i = 0; i < n; i++) cycle(r, 1'b0);
  endtask

  initial begin
    #1;
    check("pwrup_stage", stage_rst, 4'b1111);
    check("pwrup_ready", all_ready, 1'b0);
    check("pwrup_uptime", uptime, 0);
    check("pwrup_cycles", rst_cycles, 0);
    check("pwrup_err", err, 1'b0);

    // no reset ever applied: stages still release
    run(1'b0, 70);
    check("norst_stage", stage_rst, 4'b0000);
    check("norst_cycles", rst_cycles, 0);

    // legal 5120-cycle pulse
    run(1'b1, 5120);
    run(1'b0, 16);
    check("legal_cycles", rst_cycles, 5120);
    check("legal_err", err, 1'b0);
    check("legal_s16", stage_rst, 4'b1110);
    run(1'b0, 48);
    check("legal_s64", stage_rst, 4'b0000);
    check("legal_ready", all_ready, 1'b1);
    check("sat8_len", cyc8, 255);

    // short pulse then clear
    run(1'b1, 100);
    run(1'b0, 5);
    check("short_cycles", rst_cycles, 100);
    check("short_err", err, 1'b1);
    cycle(1'b0, 1'b1);
    check("clr_err", err, 1'b0);
    check("clr_cycles", rst_cycles, 100);

    // reassert mid-sequence
    run(1'b1, 20);
    run(1'b0, 40);
    check("mid_stage", stage_rst, 4'b1100);
    cycle(1'b1, 1'b0);
    check("reassert_stage", stage_rst, 4'b1111);
    check("reassert_up", uptime, 0);
    run(1'b0, 70);

    // 1-cycle glitch
    cycle(1'b1, 1'b0);
    check("glitch_ready", all_ready, 1'b0);
    run(1'b0, 63);
    check("glitch_cycles", rst_cycles, 1);
    check("glitch_err", err, 1'b1);
    check("glitch_ready63", all_ready, 1'b0);
    cycle(1'b0, 1'b1);
    check("glitch_ready64", all_ready, 1'b1);

    // clear on the capture edge loses to the set
    run(1'b1, 10);
    cycle(1'b0, 1'b1);
    check("setwins_err", err, 1'b1);
    cycle(1'b0, 1'b1);
    check("clrlater_err", err, 1'b0);

    // uptime and 8-bit saturation
    run(1'b1, 300);
    run(1'b0, 1000);
    check("uptime_1000", uptime, 1000);
    check("uptime8_sat", up8, 255);
    check("len8_sat", cyc8, 255);

    // randomized pulse / gap mix with stray clears
    for (int it = 0; it < 40; it++) begin
      int hl, ll;
      hl = ($urandom_range(0, 5) == 0) ?
           $urandom_range(5100, 5200) : $urandom_range(1, 300);
      ll = $urandom_range(1, 150);
      for (int i = 0; i < hl; i++)
        cycle(1'b1, $urandom_range(0, 7) == 0);
      for (int i = 0; i < ll; i++)
        cycle(1'b0, $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
